// File: rtl/traffic_lights_xing.sv
// Multi-direction intersection controller: round-robin service of DIRS signal
// heads with all-red clearance, per-direction green times and a night-blink mode.
module traffic_lights_xing #(
  parameter int DIRS                 = 2,
  parameter int CLK_FREQ_HZ          = 2000,
  parameter int BLINK_HALF_PERIOD_MS = 100,
  parameter int BLINK_PERIODS        = 3,
  parameter int RED_YELLOW_MS        = 90,
  parameter int GREEN_DEFAULT_MS     = 1000,
  parameter int YELLOW_DEFAULT_MS    = 300,
  parameter int ALL_RED_DEFAULT_MS   = 200,
  localparam int DW = (DIRS > 1) ? $clog2(DIRS) : 1
) (
  input  logic            clk_i,
  input  logic            srst_i,
  input  logic            cmd_valid_i,
  input  logic [2:0]      cmd_type_i,
  input  logic [DW-1:0]   cmd_dir_i,
  input  logic [15:0]     cmd_data_i,
  output logic [DIRS-1:0] red_o,
  output logic [DIRS-1:0] yellow_o,
  output logic [DIRS-1:0] green_o,
  output logic [DW-1:0]   active_dir_o
);

  localparam int TPM = CLK_FREQ_HZ / 1000;
  localparam int TW  = $clog2(65535 * TPM + 1);
  localparam logic [TW-1:0] RY_TICKS    = TW'(RED_YELLOW_MS * TPM);
  localparam logic [TW-1:0] BLINK_TICKS = TW'(2 * BLINK_HALF_PERIOD_MS * BLINK_PERIODS * TPM);
  localparam logic [TW-1:0] HALF_TICKS  = TW'(BLINK_HALF_PERIOD_MS * TPM);

  localparam logic [2:0] CMD_ON = 3'd0, CMD_OFF = 3'd1, CMD_NOTRANS = 3'd2;
  localparam logic [2:0] CMD_SET_GREEN = 3'd3, CMD_SET_YELLOW = 3'd4, CMD_SET_ALL_RED = 3'd5;

  typedef enum logic [2:0] {
    S_OFF, S_NOTRANS, S_ALL_RED, S_RED_YELLOW, S_GREEN, S_GREEN_BLINK, S_YELLOW
  } state_t;

  state_t          r_state, w_next;
  logic [TW-1:0]   r_timer, w_load_val;
  logic [TW-1:0]   r_blink_cnt;
  logic            r_blink_on;
  logic [DW-1:0]   r_dir, w_dir_next;
  logic            r_hold_dir, w_hold_next;
  logic            w_load, w_timed, w_expire;
  logic [15:0]     r_green_ms [DIRS];
  logic [15:0]     r_yellow_ms, r_all_red_ms;
  logic [15:0]     w_set_val;
  logic [DIRS-1:0] w_mask, w_red, w_yellow, w_green;

  function automatic logic [TW-1:0] ms2t(input logic [15:0] ms);
    return TW'(ms) * TW'(TPM);
  endfunction

  assign w_set_val = (cmd_data_i == 16'd0) ? 16'd1 : cmd_data_i;
  assign w_mask    = {{(DIRS-1){1'b0}}, 1'b1} << r_dir;

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_load_val  = r_timer;
    w_dir_next  = r_dir;
    w_hold_next = r_hold_dir;
    w_timed     = (r_state != S_OFF) && (r_state != S_NOTRANS);
    w_expire    = w_timed && (r_timer == TW'(1));
    // Mode commands take priority over a coinciding timer expiry.
    if (cmd_valid_i && (cmd_type_i == CMD_ON)) begin
      w_next      = S_ALL_RED;
      w_load      = 1'b1;
      w_load_val  = ms2t(r_all_red_ms);
      w_dir_next  = DW'(DIRS - 1);
      w_hold_next = 1'b0;
    end else if (cmd_valid_i && (cmd_type_i == CMD_OFF)) begin
      w_next = S_OFF;
      w_load = 1'b1;
    end else if (cmd_valid_i && (cmd_type_i == CMD_NOTRANS)) begin
      w_next = S_NOTRANS;
      w_load = 1'b1;
    end else if (w_expire) begin
      w_load = 1'b1;
      case (r_state)
        S_ALL_RED: begin
          w_next      = S_RED_YELLOW;
          w_load_val  = RY_TICKS;
          w_hold_next = 1'b0;
          // The first clearance after reset serves direction 0 without advancing.
          if (!r_hold_dir)
            w_dir_next = (r_dir == DW'(DIRS - 1)) ? '0 : r_dir + DW'(1);
        end
        S_RED_YELLOW: begin
          w_next     = S_GREEN;
          w_load_val = ms2t(r_green_ms[r_dir]);
        end
        S_GREEN: begin
          w_next     = S_GREEN_BLINK;
          w_load_val = BLINK_TICKS;
        end
        S_GREEN_BLINK: begin
          w_next     = S_YELLOW;
          w_load_val = ms2t(r_yellow_ms);
        end
        S_YELLOW: begin
          w_next     = S_ALL_RED;
          w_load_val = ms2t(r_all_red_ms);
        end
        default: w_load = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_red    = '0;
    w_yellow = '0;
    w_green  = '0;
    case (r_state)
      S_ALL_RED:     w_red = '1;
      S_RED_YELLOW:  begin w_red = '1;      w_yellow = w_mask; end
      S_GREEN:       begin w_red = ~w_mask; w_green  = w_mask; end
      S_GREEN_BLINK: begin w_red = ~w_mask; w_green  = r_blink_on ? w_mask : '0; end
      S_YELLOW:      begin w_red = ~w_mask; w_yellow = w_mask; end
      S_NOTRANS:     w_yellow = {DIRS{r_blink_on}};
      default:       w_red = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state      <= S_ALL_RED;
      r_timer      <= ms2t(16'(ALL_RED_DEFAULT_MS));
      r_dir        <= '0;
      r_hold_dir   <= 1'b1;
      r_blink_cnt  <= '0;
      r_blink_on   <= 1'b1;
      for (int i = 0; i < DIRS; i++) r_green_ms[i] <= 16'(GREEN_DEFAULT_MS);
      r_yellow_ms  <= 16'(YELLOW_DEFAULT_MS);
      r_all_red_ms <= 16'(ALL_RED_DEFAULT_MS);
      red_o        <= '0;
      yellow_o     <= '0;
      green_o      <= '0;
      active_dir_o <= '0;
    end else begin
      r_state    <= w_next;
      r_dir      <= w_dir_next;
      r_hold_dir <= w_hold_next;
      if (w_load)       r_timer <= w_load_val;
      else if (w_timed) r_timer <= r_timer - TW'(1);
      // Blink phase restarts on every state entry so each blink begins lit.
      if (w_load) begin
        r_blink_cnt <= '0;
        r_blink_on  <= 1'b1;
      end else if (r_blink_cnt == HALF_TICKS - TW'(1)) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + TW'(1);
      end
      if (cmd_valid_i && (cmd_type_i == CMD_SET_GREEN) && (int'(cmd_dir_i) < DIRS))
        r_green_ms[cmd_dir_i] <= w_set_val;
      if (cmd_valid_i && (cmd_type_i == CMD_SET_YELLOW))  r_yellow_ms  <= w_set_val;
      if (cmd_valid_i && (cmd_type_i == CMD_SET_ALL_RED)) r_all_red_ms <= w_set_val;
      red_o        <= w_red;
      yellow_o     <= w_yellow;
      green_o      <= w_green;
      active_dir_o <= r_dir;
    end
  end

endmodule
